// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: queues AES-CTR descriptors and launches them one at a time into the
// streaming datapath, waiting for both stream dones under a watchdog.
module aes_job_scheduler #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         desc_valid,
  output logic         desc_ready,
  input  logic [63:0]  desc_src,
  input  logic [63:0]  desc_dst,
  input  logic [63:0]  desc_len,
  input  logic [127:0] desc_iv,
  output logic [63:0]  dp_src,
  output logic [63:0]  dp_dst,
  output logic [63:0]  dp_len,
  output logic [127:0] dp_iv,
  output logic         dp_run,
  output logic         dp_abort,
  input  logic         dp_rd_done,
  input  logic         dp_wr_done,
  input  logic         clear_stats,
  output logic         idle,
  output logic [31:0]  jobs_done,
  output logic         zero_len_seen,
  output logic         timeout_seen
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} state_t;
  state_t state_q, state_d;
  logic [319:0] mem_q [DEPTH];
  logic [319:0] head;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [CW-1:0] wd_q;
  logic [31:0] jobs_q, jobs_d;
  logic [63:0] src_q, dst_q, len_q;
  logic [127:0] iv_q;
  logic rd_q, wr_q, idle_q, zl_q, zl_d, to_q, to_d;
  logic push, pop, len0, done_now, expire, inc;
  assign desc_ready = cnt_q != (AW+1)'(DEPTH);
  assign push = desc_valid && desc_ready;
  assign pop = (state_q == IDLE) && (cnt_q != '0);
  assign head = mem_q[rp_q];
  assign len0 = head[191:128] == '0;
  // Sticky latches or same-cycle inputs both count towards completion
  assign done_now = (state_q == WAIT) && (rd_q || dp_rd_done) && (wr_q || dp_wr_done);
  assign expire = (state_q == WAIT) && !done_now && (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (pop && !len0) ? LOAD : IDLE;
      LOAD:    state_d = RUN;
      RUN:     state_d = WAIT;
      default: state_d = (done_now || expire) ? IDLE : WAIT;
    endcase
    inc = (pop && len0) || done_now;
    zl_d = (zl_q && !clear_stats) || (pop && len0);
    to_d = (to_q && !clear_stats) || expire;
    jobs_d = (clear_stats ? 32'd0 : jobs_q) + 32'(inc);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {desc_src, desc_dst, desc_len, desc_iv};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      wd_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      idle_q <= 1'b1;
      zl_q <= 1'b0;
      to_q <= 1'b0;
      jobs_q <= '0;
      {src_q, dst_q, len_q, iv_q} <= '0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_d;
      wd_q <= (state_q == WAIT) ? wd_q + CW'(1) : '0;
      rd_q <= (state_q == WAIT) && (rd_q || dp_rd_done);
      wr_q <= (state_q == WAIT) && (wr_q || dp_wr_done);
      idle_q <= (state_d == IDLE) && (cnt_d == '0);
      zl_q <= zl_d;
      to_q <= to_d;
      jobs_q <= jobs_d;
      if (pop) {src_q, dst_q, len_q, iv_q} <= head;
    end
  end
  assign dp_src = src_q;
  assign dp_dst = dst_q;
  assign dp_len = len_q;
  assign dp_iv = iv_q;
  assign dp_run = state_q == RUN;
  assign dp_abort = expire;
  assign idle = idle_q;
  assign jobs_done = jobs_q;
  assign zero_len_seen = zl_q;
  assign timeout_seen = to_q;
endmodule
